// File: rtl/segre_mem_arbiter.sv
// rtl/segre_mem_arbiter.sv - Shares the main-memory port between IC and DC refills with a fixed-latency FSM.
// Optional MEM_ARB_ROUND_ROBIN_EN: alternate grants on contention instead of fixed IC priority.
module segre_mem_arbiter #(
    parameter int ADDR_SIZE   = 32,
    parameter int LINE_SIZE   = 128,
    parameter int MEM_LATENCY = 5
) (
    input  logic                 clk_i,
    input  logic                 rsn_i,
    input  logic                 ic_req_i,
    input  logic [ADDR_SIZE-1:0] ic_addr_i,
    input  logic                 dc_req_i,
    input  logic                 dc_we_i,
    input  logic [ADDR_SIZE-1:0] dc_addr_i,
    input  logic [LINE_SIZE-1:0] dc_wdata_i,
    input  logic [LINE_SIZE-1:0] mm_rdata_i,
    output logic                 mm_req_o,
    output logic                 mm_we_o,
    output logic [ADDR_SIZE-1:0] mm_addr_o,
    output logic [LINE_SIZE-1:0] mm_wdata_o,
    output logic                 sel_mem_req_o,
    output logic                 busy_o,
    output logic                 ic_rsp_valid_o,
    output logic                 dc_rsp_valid_o,
    output logic [LINE_SIZE-1:0] rsp_data_o
);

    localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 owner_q, owner_d;
    logic                 we_q, we_d;
    logic [ADDR_SIZE-1:0] addr_q, addr_d;
    logic [LINE_SIZE-1:0] wdata_q, wdata_d;
    logic                 grant_dc;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic last_owner_q, last_owner_d;

    // On contention the side that did not win last time is served.
    always_comb begin
        if (ic_req_i && dc_req_i) begin
            grant_dc = ~last_owner_q;
        end else begin
            grant_dc = dc_req_i;
        end
    end
`else
    always_comb begin
        grant_dc = ~ic_req_i;
    end
`endif

    always_ff @(posedge clk_i) begin
        if (!rsn_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rsn_i) begin
            cnt_q   <= '0;
            owner_q <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            owner_q <= owner_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

`ifdef MEM_ARB_ROUND_ROBIN_EN
    always_ff @(posedge clk_i) begin
        if (!rsn_i) begin
            last_owner_q <= 1'b1;
        end else begin
            last_owner_q <= last_owner_d;
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        owner_d = owner_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        last_owner_d = last_owner_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (ic_req_i || dc_req_i) begin
                    state_d = ST_BUSY;
                    cnt_d   = CNT_W'(MEM_LATENCY - 1);
                    owner_d = grant_dc;
                    we_d    = grant_dc & dc_we_i;
                    addr_d  = grant_dc ? dc_addr_i : ic_addr_i;
                    wdata_d = grant_dc ? dc_wdata_i : '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
                    last_owner_d = grant_dc;
`endif
                end
            end
            ST_BUSY: begin
                if (cnt_q == '0) begin
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        mm_req_o       = (state_q == ST_BUSY);
        mm_we_o        = mm_req_o & we_q;
        mm_addr_o      = mm_req_o ? addr_q : '0;
        mm_wdata_o     = mm_req_o ? wdata_q : '0;
        sel_mem_req_o  = owner_q;
        busy_o         = (state_q != ST_IDLE);
        ic_rsp_valid_o = (state_q == ST_RESP) & ~owner_q;
        dc_rsp_valid_o = (state_q == ST_RESP) & owner_q;
        rsp_data_o     = ((state_q == ST_RESP) && !we_q) ? mm_rdata_i : '0;
    end

endmodule

// File: tb/tb_segre_mem_arbiter.sv
// tb/tb_segre_mem_arbiter.sv - Randomized scoreboard bench for segre_mem_arbiter.
module tb_segre_mem_arbiter;

    localparam int L = 5;

    logic         clk = 1'b0;
    logic         rsn = 1'b0;
    logic         ic_req = 1'b0;
    logic [31:0]  ic_addr = '0;
    logic         dc_req = 1'b0;
    logic         dc_we = 1'b0;
    logic [31:0]  dc_addr = '0;
    logic [127:0] dc_wdata = '0;
    logic [127:0] mm_rdata = '0;
    logic         mm_req, mm_we, sel, busy, ic_rsp, dc_rsp;
    logic [31:0]  mm_addr;
    logic [127:0] mm_wdata, rsp_data;

    segre_mem_arbiter #(.ADDR_SIZE(32), .LINE_SIZE(128), .MEM_LATENCY(L)) dut (
        .clk_i(clk), .rsn_i(rsn),
        .ic_req_i(ic_req), .ic_addr_i(ic_addr),
        .dc_req_i(dc_req), .dc_we_i(dc_we), .dc_addr_i(dc_addr), .dc_wdata_i(dc_wdata),
        .mm_rdata_i(mm_rdata),
        .mm_req_o(mm_req), .mm_we_o(mm_we), .mm_addr_o(mm_addr), .mm_wdata_o(mm_wdata),
        .sel_mem_req_o(sel), .busy_o(busy),
        .ic_rsp_valid_o(ic_rsp), .dc_rsp_valid_o(dc_rsp), .rsp_data_o(rsp_data)
    );

    typedef struct {
        logic         owner;
        logic         we;
        logic [31:0]  addr;
        logic [127:0] wdata;
        int           cyc;
    } txn_t;

    txn_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   busy_cnt = 0;
    bit   mon_en = 1'b0;
    bit   last_owner = 1'b1;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        forever begin
            @(posedge clk);
            #2 mm_rdata = {$urandom, $urandom, $urandom, $urandom};
        end
    end

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h (cyc %0d)", name, got, exp, cyc);
        end
    endtask

    // Scoreboard monitor: every busy cycle and every response is compared against the queue head.
    always @(negedge clk) begin
        if (mon_en) begin
            if (ic_rsp && dc_rsp) chk("both_rsp", 1, 0);
            if (mm_req) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_busy", 1, 0);
                end else begin
                    chk("mm_addr", mm_addr, exp_q[0].addr);
                    chk("mm_we", mm_we, exp_q[0].we);
                    chk("mm_wdata", mm_wdata, exp_q[0].wdata);
                    chk("sel_busy", sel, exp_q[0].owner);
                    busy_cnt++;
                end
            end
            if (ic_rsp || dc_rsp) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_rsp", 1, 0);
                end else begin
                    chk("rsp_owner", dc_rsp, exp_q[0].owner);
                    chk("sel_resp", sel, exp_q[0].owner);
                    chk("rsp_data", rsp_data, exp_q[0].we ? 128'h0 : mm_rdata);
                    chk("busy_len", busy_cnt, L);
                    chk("rsp_cycle", cyc, exp_q[0].cyc);
                    chk("mm_req_in_resp", mm_req, 0);
                    void'(exp_q.pop_front());
                end
                busy_cnt = 0;
            end
        end
    end

    task automatic run_phase(input bit ic_on, input bit dc_on, input logic [31:0] ia,
                             input logic [31:0] da, input bit dwe, input logic [127:0] dwd,
                             input bit drop_first);
        bit   order[2];
        int   n;
        int   t0;
        int   cnt;
        bit   seen;
        txn_t t;
        t0 = cyc;
        if (ic_on && dc_on) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            order[0] = ~last_owner;
`else
            order[0] = 1'b0;
`endif
            order[1] = ~order[0];
            n = 2;
        end else begin
            order[0] = dc_on;
            order[1] = 1'b0;
            n = 1;
        end
        last_owner = order[n-1];
        for (int k = 0; k < n; k++) begin
            t.owner = order[k];
            t.we    = order[k] ? dwe : 1'b0;
            t.addr  = order[k] ? da : ia;
            t.wdata = order[k] ? dwd : 128'h0;
            t.cyc   = t0 + (k + 1) * (L + 2) - 1;
            exp_q.push_back(t);
        end
        ic_req = ic_on; ic_addr = ia;
        dc_req = dc_on; dc_addr = da; dc_we = dwe; dc_wdata = dwd;
        for (int k = 0; k < n; k++) begin
            cnt = 0;
            seen = 1'b0;
            while (!seen && cnt < 4 * L + 20) begin
                @(negedge clk);
                cnt++;
                if (k == 0 && cnt == 3) begin
                    if (order[0]) begin
                        dc_addr = $urandom; dc_we = $urandom; dc_wdata = {4{$urandom}};
                        if (drop_first) dc_req = 1'b0;
                    end else begin
                        ic_addr = $urandom;
                        if (drop_first) ic_req = 1'b0;
                    end
                end
                seen = order[k] ? dc_rsp : ic_rsp;
            end
            if (!seen) chk("rsp_timeout", 0, 1);
            @(posedge clk);
            #1;
            if (order[k]) dc_req = 1'b0;
            else ic_req = 1'b0;
        end
    endtask

    initial begin
        int gap;
        int sel_r;
        bit seen_rsp;
        // Reset with both requests held high.
        rsn = 1'b0; ic_req = 1'b1; dc_req = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("reset_outputs", {mm_req, mm_we, mm_addr, mm_wdata, sel, busy, ic_rsp, dc_rsp, rsp_data}, '0);
        chk("reset_busy", busy, 0);
        @(posedge clk); #1;
        rsn = 1'b1; ic_req = 1'b0; dc_req = 1'b0;
        mon_en = 1'b1;
        @(posedge clk); #1;

        run_phase(1, 0, 32'h100, 32'h0, 0, 128'h0, 0);
        run_phase(0, 1, 32'h0, 32'h2040, 1, {16{8'hA5}}, 0);
        run_phase(1, 1, 32'h3000, 32'h4000, 0, 128'h0, 0);
        run_phase(1, 0, 32'h500, 32'h0, 0, 128'h0, 1);
        for (int i = 0; i < 40; i++) begin
            sel_r = $urandom_range(1, 3);
            run_phase(sel_r[0], sel_r[1], $urandom, $urandom, $urandom_range(0, 1),
                      {$urandom, $urandom, $urandom, $urandom}, $urandom_range(0, 3) == 0);
            gap = $urandom_range(0, 2);
            repeat (gap) begin
                @(posedge clk); #1;
            end
        end

        // Reset in the middle of a DC read: no response, back to idle.
        mon_en = 1'b0;
        dc_req = 1'b1; dc_we = 1'b0; dc_addr = 32'h7700;
        repeat (3) begin
            @(posedge clk); #1;
        end
        rsn = 1'b0; dc_req = 1'b0;
        @(posedge clk); #1;
        rsn = 1'b1;
        last_owner = 1'b1;
        exp_q.delete();
        busy_cnt = 0;
        seen_rsp = 1'b0;
        @(negedge clk);
        chk("abort_idle", busy, 0);
        repeat (L + 4) begin
            @(negedge clk);
            if (dc_rsp || ic_rsp || busy) seen_rsp = 1'b1;
        end
        chk("abort_no_rsp", seen_rsp, 0);
        @(posedge clk); #1;
        mon_en = 1'b1;

        for (int i = 0; i < 6; i++) begin
            sel_r = $urandom_range(1, 3);
            run_phase(sel_r[0], sel_r[1], $urandom, $urandom, $urandom_range(0, 1),
                      {$urandom, $urandom, $urandom, $urandom}, 0);
        end
        repeat (3) @(negedge clk);
        chk("queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
